// File: rtl/frame_pkg.sv
// Shared definitions for the frame deserializer: state codes and default width.
package frame_pkg;

    // Default payload width, in bits per frame.
    localparam int DEFAULT_DATA_W = 8;

    // Receiver state codes, kept as plain constants so older tools can consume them.
    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_DATA = 2'd1;
    localparam state_t S_STOP = 2'd2;

    // Bit-counter width for a given payload width (at least one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/frame_shreg.sv
// Word assembly register: each sampled payload bit is written into the
// position selected by the bit counter, so bit 0 of the word is the first
// bit received. The register is cleared on a start bit so a truncated
// frame never mixes with bits of an earlier one.
module frame_shreg
    import frame_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = cnt_width(DEFAULT_DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [CNT_W-1:0]  i_idx,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_word
);

    logic [DATA_W-1:0] r_word;

    // Clear on start bit, otherwise write the sampled bit at the counter position.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word <= '0;
        end else if (i_clr) begin
            r_word <= '0;
        end else if (i_load) begin
            r_word[i_idx] <= i_bit;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/frame_deserializer.sv
// Serial frame receiver: start bit (0), DATA_W payload bits LSB first, one
// stop bit (1). Completed words are handed downstream through a single
// holding register with a valid/ready handshake. A bad stop bit raises a
// one-cycle frame_err; a good word arriving while the holding register is
// still occupied is dropped with a one-cycle overrun.
module frame_deserializer
    import frame_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int               CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;

    logic              w_start;
    logic              w_shift_en;
    logic              w_stop_edge;
    logic              w_take;
    logic              w_load;
    logic              w_drop;
    logic              w_bad_stop;

    // Decode the sample strobe against the current state; nothing moves without bit_en.
    assign w_start     = bit_en && (r_state == S_IDLE) && !serial_in;
    assign w_shift_en  = bit_en && (r_state == S_DATA);
    assign w_stop_edge = bit_en && (r_state == S_STOP);

    // Holding-register decisions at the stop-bit sample. A word that arrives
    // on the same edge the old one is taken replaces it without a gap.
    assign w_take      = r_valid && ready;
    assign w_load      = w_stop_edge && serial_in && (!r_valid || ready);
    assign w_drop      = w_stop_edge && serial_in && r_valid && !ready;
    assign w_bad_stop  = w_stop_edge && !serial_in;

    // Next state and bit counter, evaluated only on sample strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (bit_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!serial_in) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DATA: begin
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt = S_STOP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Payload assembly, one bit per DATA-state sample.
    frame_shreg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_load (w_shift_en),
        .i_idx  (r_cnt),
        .i_bit  (serial_in),
        .o_word (w_word)
    );

    // Holding register: load a good word, otherwise release it on handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (w_take) begin
            r_valid <= 1'b0;
        end
    end

    // Single-cycle error pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            r_overrun   <= w_drop;
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: doc/frame_deserializer.md
FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload bits per frame (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low (rst==0 at a rising clk edge resets the block).
REQ-004 SHALL have port serial_in  input  1  registered serial bit from the upstream capture flop.
REQ-005 SHALL have port bit_en  input  1  sample strobe; serial_in is consumed only on edges where bit_en==1.
REQ-006 SHALL have port data  output  DATA_W  assembled word, LSB received first.
REQ-007 SHALL have port valid  output  1  data holds an unconsumed word.
REQ-008 SHALL have port ready  input  1  downstream accepts the word when valid&&ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: completed word dropped because the holding register was full.

Function
REQ-011 SHALL implement FSM states IDLE, DATA, STOP; state and bit counter change only on edges with bit_en==1.
REQ-012 SHALL, in IDLE, move to DATA and clear the bit counter when serial_in==0 is sampled (start bit); serial_in==1 keeps IDLE.
REQ-013 SHALL, in DATA, shift each sample into bit position (counter), counter 0..DATA_W-1, counter width $clog2(DATA_W); after sample DATA_W-1, move to STOP.
REQ-014 SHALL, in STOP, return to IDLE on the sample regardless of its value.
REQ-015 SHALL, on a STOP sample of 1, load the word into data and set valid on the same edge (valid visible the cycle after the stop-bit edge) if valid==0 or valid&&ready on that edge.
REQ-016 SHALL, on a STOP sample of 1 with valid==1 and ready==0, drop the new word, keep data/valid unchanged, and pulse overrun for one cycle.
REQ-017 SHALL, on a STOP sample of 0, discard the word, leave data/valid unchanged, and pulse frame_err for one cycle.
REQ-018 SHALL clear valid on an edge with valid&&ready unless a new word loads on that same edge (then valid stays 1 with new data).
REQ-019 SHALL hold data stable while valid==1 and ready==0.
REQ-020 SHALL ignore ready while valid==0; frame_err and overrun SHALL be 0 on all other cycles.
REQ-021 SHALL tolerate arbitrary bit_en gaps (including bit_en held low indefinitely) without state change.

Reset
REQ-022 SHALL, when rst==0 at a clk edge, set state=IDLE, counter=0, data=0, valid=0, frame_err=0, overrun=0, overriding bit_en, ready and any in-progress frame.
REQ-023 SHALL resume normal operation on the first edge with rst==1, treating it as IDLE.

Structure
REQ-024 SHALL place the state enumeration (IDLE, DATA, STOP) and the default DATA_W constant in shared package frame_pkg.
REQ-025 SHALL isolate the shift/assembly register with counter-indexed load in one sub-module, frame_shreg; FSM, holding register and handshake stay in frame_deserializer.

Verification
REQ-026 SHALL cover: bit_en=1 every cycle, bits 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB-first, stop), ready=1 -> data=0xA5, valid=1 for exactly one cycle after the stop edge.
REQ-027 SHALL cover: 0x3C frame with stop bit 0 -> frame_err single-cycle pulse, valid stays 0, data stays 0.
REQ-028 SHALL cover: ready=0, frames 0x11 then 0x22 -> data=0x11 valid=1, overrun pulse at 0x22 stop edge, data still 0x11; then ready=1 -> valid drops next edge.
REQ-029 SHALL cover: rst=0 after 4 data bits of a frame -> all outputs 0, IDLE; following full 0x3C frame received exactly.
REQ-030 SHALL cover: bit_en asserted every 3rd cycle for frame 0x5A, with ready pulsed on the stop edge of a pending word 0x01 -> data switches 0x01->0x5A with valid held 1, no overrun.
